// File: rtl/hazard_ctrl.sv
// Pipeline control for the five-stage CPU: per-cycle advance/hold/bubble decisions
// for PC and the four pipeline registers, covering load-use, taken branch and memory wait.
module hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              read_mem_EX,
    input  logic [REG_AW-1:0] wite_reg_addr_EX,
    input  logic              branch_taken_EX,
    input  logic              mem_req,
    input  logic              mem_ack,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              mem_wb_bubble,
    output logic              err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              r_err;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic              w_mem_stall;
    logic              w_load_use;
    logic              w_flush_event;

    // A load whose destination is a real register and is read by the ID instruction.
    assign w_mem_stall = mem_req && !mem_ack;
    assign w_load_use  = read_mem_EX && (wite_reg_addr_EX != '0) &&
                         ((id_uses_rs && (id_rs_addr == wite_reg_addr_EX)) ||
                          (id_uses_rt && (id_rt_addr == wite_reg_addr_EX)));

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        mem_wb_bubble = 1'b0;
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_flush_event = 1'b0;

        if (rst) begin
            // Pipeline registers have no reset: hold them and feed bubbles.
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
            {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble} = '1;
            w_state_nxt = RUN;
            w_wait_nxt  = '0;
        end else begin
            case (r_state)
                ERR: begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
                    mem_wb_bubble = 1'b1;
                end
                default: begin
                    if (w_mem_stall) begin
                        {pc_en, if_id_en, id_ex_en, ex_mem_en} = '0;
                        mem_wb_bubble = 1'b1;
                        if (r_wait_cnt == WAIT_LAST) begin
                            w_state_nxt = ERR;
                            w_wait_nxt  = '0;
                        end else begin
                            w_state_nxt = MEM_WAIT;
                            w_wait_nxt  = r_wait_cnt + 1'b1;
                        end
                    end else begin
                        w_state_nxt = RUN;
                        w_wait_nxt  = '0;
                        if (branch_taken_EX) begin
                            if_id_flush   = 1'b1;
                            id_ex_flush   = 1'b1;
                            w_flush_event = 1'b1;
                        end else if (w_load_use) begin
                            pc_en       = 1'b0;
                            if_id_en    = 1'b0;
                            id_ex_flush = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only control state is reset; the outputs above already force bubbles during reset.
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_state_nxt == ERR) begin
                r_err <= 1'b1;
            end
            if (!pc_en && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_event) begin
                r_flush_cnt <= (r_flush_cnt >= CNT_MAX - 1'b1) ? CNT_MAX
                                                               : r_flush_cnt + CNT_W'(2);
            end
        end
    end

    assign err       = r_err;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, multi-cycle sequences
// and randomized traffic against a priority-rule reference model.
module tb_hazard_ctrl;

    localparam int REG_AW      = 5;
    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic [REG_AW-1:0] id_rs_addr, id_rt_addr, wite_reg_addr_EX;
    logic              id_uses_rs, id_uses_rt, read_mem_EX, branch_taken_EX;
    logic              mem_req, mem_ack;
    logic              pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic              if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble;
    logic              err;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    hazard_ctrl #(.REG_AW(REG_AW), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .read_mem_EX(read_mem_EX), .wite_reg_addr_EX(wite_reg_addr_EX),
        .branch_taken_EX(branch_taken_EX), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_bubble(mem_wb_bubble),
        .err(err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, ex_mem flush, mem_wb bubble}
    logic [8:0] dut_ctrl;
    assign dut_ctrl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble};

    localparam logic [8:0] C_RESET  = 9'b00000_1111;
    localparam logic [8:0] C_NORMAL = 9'b11111_0000;
    localparam logic [8:0] C_LU     = 9'b00111_0100;
    localparam logic [8:0] C_BRANCH = 9'b11111_1100;
    localparam logic [8:0] C_MEM    = 9'b00001_0001;
    localparam logic [8:0] C_ERR    = 9'b00000_0001;

    typedef struct {
        string             name;
        logic              rmem;
        logic [REG_AW-1:0] wr, rs, rt;
        logic              urs, urt, br, req, ack;
        logic [8:0]        exp;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts consecutive stall cycles instead of tracking an FSM.
    int m_err, m_waited, m_stall, m_flush;

    function automatic logic [8:0] model_ctrl();
        logic lu;
        lu = read_mem_EX && (wite_reg_addr_EX != 0) &&
             ((id_uses_rs && id_rs_addr == wite_reg_addr_EX) ||
              (id_uses_rt && id_rt_addr == wite_reg_addr_EX));
        if (rst)                        return C_RESET;
        if (m_err != 0)                 return C_ERR;
        if (mem_req && !mem_ack)        return C_MEM;
        if (branch_taken_EX)            return C_BRANCH;
        if (lu)                         return C_LU;
        return C_NORMAL;
    endfunction

    task automatic model_update(input logic [8:0] ctrl);
        if (rst) begin
            m_err = 0; m_waited = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!ctrl[8]) m_stall = (m_stall + 1 > CNT_MAX) ? CNT_MAX : m_stall + 1;
            if (ctrl == C_BRANCH) m_flush = (m_flush + 2 > CNT_MAX) ? CNT_MAX : m_flush + 2;
            if (m_err == 0) begin
                if (mem_req && !mem_ack) begin
                    m_waited++;
                    if (m_waited >= MEM_TIMEOUT) m_err = 1;
                end else begin
                    m_waited = 0;
                end
            end
        end
    endtask

    // One clock: inputs already driven; check at negedge, then advance the model at posedge.
    task automatic cycle(input string tname = "", input logic has_exp = 1'b0,
                         input logic [8:0] texp = '0);
        logic [8:0] exp;
        @(negedge clk);
        exp = model_ctrl();
        if (has_exp) check(tname, dut_ctrl, texp);
        check("ctrl", dut_ctrl, exp);
        check("err", err, m_err);
        check("stall_cnt", stall_cnt, m_stall);
        check("flush_cnt", flush_cnt, m_flush);
        @(posedge clk);
        model_update(exp);
        #1;
    endtask

    task automatic apply(input vec_t v);
        read_mem_EX = v.rmem; wite_reg_addr_EX = v.wr;
        id_rs_addr = v.rs; id_rt_addr = v.rt;
        id_uses_rs = v.urs; id_uses_rt = v.urt;
        branch_taken_EX = v.br; mem_req = v.req; mem_ack = v.ack;
    endtask

    task automatic idle();
        read_mem_EX = 0; wite_reg_addr_EX = '0; id_rs_addr = '0; id_rt_addr = '0;
        id_uses_rs = 0; id_uses_rt = 0; branch_taken_EX = 0; mem_req = 0; mem_ack = 0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle();
        repeat (n) cycle("reset_ctrl", 1'b1, C_RESET);
        rst = 1'b0;
    endtask

    vec_t vecs[8];
    vec_t v_lu, v_br, v_mem, v_ack, v_mem_br, v_ack_br;

    initial begin
        //           name          rmem wr  rs  rt  urs urt br req ack exp
        vecs[0] = '{"normal",      0,   0,  0,  0,  0,  0,  0, 0,  0,  C_NORMAL};
        vecs[1] = '{"lu_rs",       1,   5,  5,  3,  1,  0,  0, 0,  0,  C_LU};
        vecs[2] = '{"lu_r0",       1,   0,  0,  0,  1,  1,  0, 0,  0,  C_NORMAL};
        vecs[3] = '{"lu_rt",       1,   9,  2,  9,  0,  1,  0, 0,  0,  C_LU};
        vecs[4] = '{"lu_rt_unused",1,   9,  2,  9,  1,  0,  0, 0,  0,  C_NORMAL};
        vecs[5] = '{"branch_lu",   1,   5,  5,  0,  1,  0,  1, 0,  0,  C_BRANCH};
        vecs[6] = '{"mem_zero_wait",0,  0,  0,  0,  0,  0,  0, 1,  1,  C_NORMAL};
        vecs[7] = '{"no_load",     0,   5,  5,  5,  1,  1,  0, 0,  0,  C_NORMAL};
        v_lu     = vecs[1];
        v_br     = '{"branch",     0,   0,  0,  0,  0,  0,  1, 0,  0,  C_BRANCH};
        v_mem    = '{"mem_wait",   0,   0,  0,  0,  0,  0,  0, 1,  0,  C_MEM};
        v_ack    = '{"mem_ack",    0,   0,  0,  0,  0,  0,  0, 1,  1,  C_NORMAL};
        v_mem_br = '{"mem_br_wait",0,   0,  0,  0,  0,  0,  1, 1,  0,  C_MEM};
        v_ack_br = '{"mem_br_ack", 0,   0,  0,  0,  0,  0,  1, 1,  1,  C_BRANCH};

        rst = 1'b1;
        idle();
        m_err = 0; m_waited = 0; m_stall = 0; m_flush = 0;
        @(posedge clk);
        #1;

        do_reset(2);
        check("reset_err", err, 0);

        foreach (vecs[i]) begin
            apply(vecs[i]);
            cycle(vecs[i].name, 1'b1, vecs[i].exp);
        end
        check("table_stall_cnt", stall_cnt, 2);
        check("table_flush_cnt", flush_cnt, 2);

        // Memory wait of k=3 cycles.
        do_reset(1);
        apply(v_mem);
        repeat (3) cycle("mem_k3_wait", 1'b1, C_MEM);
        apply(v_ack);
        cycle("mem_k3_ack", 1'b1, C_NORMAL);
        check("mem_k3_stall_cnt", stall_cnt, 3);
        idle();
        cycle("mem_k3_after", 1'b1, C_NORMAL);

        // Branch held in EX during a memory stall is acted on at the ack cycle.
        do_reset(1);
        apply(v_mem_br);
        repeat (2) cycle("mem_br_wait", 1'b1, C_MEM);
        apply(v_ack_br);
        cycle("mem_br_ack", 1'b1, C_BRANCH);
        check("mem_br_flush_cnt", flush_cnt, 2);

        // Timeout: 15 stall cycles without ack, then ERR ignores ack until reset.
        do_reset(1);
        apply(v_mem);
        repeat (MEM_TIMEOUT - 1) cycle("tmo_wait", 1'b1, C_MEM);
        check("tmo_err_early", err, 0);
        cycle("tmo_last", 1'b1, C_MEM);
        check("tmo_err", err, 1);
        apply(v_ack);
        repeat (2) cycle("tmo_err_ctrl", 1'b1, C_ERR);
        check("tmo_stall_sat", stall_cnt, CNT_MAX);
        do_reset(1);
        check("tmo_err_cleared", err, 0);
        idle();
        cycle("tmo_run_after_rst", 1'b1, C_NORMAL);

        // Reset in the middle of a wait restarts the timeout count.
        apply(v_mem);
        repeat (5) cycle("midrst_wait", 1'b1, C_MEM);
        rst = 1'b1;
        cycle("midrst_rst", 1'b1, C_RESET);
        rst = 1'b0;
        repeat (MEM_TIMEOUT - 1) cycle("midrst_rewait", 1'b1, C_MEM);
        check("midrst_no_err", err, 0);
        apply(v_ack);
        cycle("midrst_ack", 1'b1, C_NORMAL);

        // Counter saturation.
        do_reset(1);
        apply(v_lu);
        repeat (20) cycle("sat_lu", 1'b1, C_LU);
        check("stall_sat", stall_cnt, CNT_MAX);
        apply(v_br);
        repeat (10) cycle("sat_br", 1'b1, C_BRANCH);
        check("flush_sat", flush_cnt, CNT_MAX);

        // Randomized traffic against the model.
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            rst              = ($urandom_range(0, 149) == 0);
            read_mem_EX      = ($urandom_range(0, 1) == 1);
            wite_reg_addr_EX = REG_AW'($urandom_range(0, 3));
            id_rs_addr       = REG_AW'($urandom_range(0, 3));
            id_rt_addr       = REG_AW'($urandom_range(0, 3));
            id_uses_rs       = ($urandom_range(0, 1) == 1);
            id_uses_rt       = ($urandom_range(0, 1) == 1);
            branch_taken_EX  = ($urandom_range(0, 4) == 0);
            mem_req          = ($urandom_range(0, 2) == 0) || (m_waited != 0 && $urandom_range(0, 9) != 0);
            mem_ack          = ($urandom_range(0, 4) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
